// File: rtl/instr_fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
//   fetch_state_e : sequencer state (IDLE, RUN, HALTED)
//   *_DEF         : default widths and reset PC used by the top-level parameters
package instr_fetch_pkg;

  localparam int          ADDR_W_DEF    = 8;
  localparam int          INSTR_LEN_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_dbg_arb.sv
// Debug/fetch arbiter for the shared instruction-memory read port.
// Debug wins whenever fetch is not using the port (not running, or stalled).
// Otherwise it waits, and after DBG_MAX_WAIT refused cycles the grant is forced.
//   clk, rst   : clock, synchronous active-high reset
//   i_dbg_req  : debug read request, held until granted
//   state_run  : fetch sequencer is in RUN
//   stall      : held output word not accepted by decode this cycle
//   gnt        : debug owns the memory port this cycle (combinational)
module fetch_dbg_arb #(
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_dbg_req,
  input  logic state_run,
  input  logic stall,
  output logic gnt
);

  localparam int CNT_W = $clog2(DBG_MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             forced;

  assign forced = (wait_cnt == CNT_W'(DBG_MAX_WAIT));
  assign gnt    = i_dbg_req & (~state_run | stall | forced);

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values; blocking assignments here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!i_dbg_req || gnt) begin
      wait_cnt <= '0;
    end else if (!forced) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction
// memory, and presents fetched words to decode over valid/ready. Supports
// redirects, start/halt, and shares the memory port with a debug reader.
//   clk, rst                    : clock, synchronous active-high reset
//   i_start / i_halt            : begin fetching / stop fetching (halt wins)
//   i_redirect, i_redirect_pc   : load a new PC and flush the held word
//   o_mem_addr, i_mem_data      : instruction memory read port
//   o_valid, o_instr, o_pc, i_ready : fetched-word handshake towards decode
//   i_dbg_req, i_dbg_addr       : debug read request (held until granted)
//   o_dbg_gnt                   : debug owns the port this cycle
//   o_dbg_valid, o_dbg_data     : debug read result, one cycle after grant
module instr_fetch_ctrl
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W       = ADDR_W_DEF,
  parameter int                INSTR_LEN    = INSTR_LEN_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC     = RESET_PC_DEF[ADDR_W-1:0],
  parameter int                DBG_MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_halt,
  input  logic                 i_redirect,
  input  logic [ADDR_W-1:0]    i_redirect_pc,
  output logic [ADDR_W-1:0]    o_mem_addr,
  input  logic [INSTR_LEN-1:0] i_mem_data,
  output logic                 o_valid,
  output logic [INSTR_LEN-1:0] o_instr,
  output logic [ADDR_W-1:0]    o_pc,
  input  logic                 i_ready,
  input  logic                 i_dbg_req,
  input  logic [ADDR_W-1:0]    i_dbg_addr,
  output logic                 o_dbg_gnt,
  output logic                 o_dbg_valid,
  output logic [INSTR_LEN-1:0] o_dbg_data
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc;
  logic              stall;
  logic              fetch_fire;

  assign stall = o_valid & ~i_ready;

  fetch_dbg_arb #(
    .DBG_MAX_WAIT(DBG_MAX_WAIT)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_dbg_req(i_dbg_req),
    .state_run(state == RUN),
    .stall    (stall),
    .gnt      (o_dbg_gnt)
  );

  assign o_mem_addr = o_dbg_gnt ? i_dbg_addr : pc;
  assign fetch_fire = (state == RUN) & ~i_halt & ~i_redirect & ~stall & ~o_dbg_gnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start && !i_halt) state_next = RUN;
      RUN:     if (i_halt)             state_next = HALTED;
      HALTED:  if (i_start && !i_halt) state_next = RUN;
      default:                         state_next = IDLE;
    endcase
  end

  // PC and decode-side output register. A redirect overrides both the fetch
  // update and the consume path so the held word is flushed unconditionally.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      o_valid <= 1'b0;
      o_instr <= '0;
      o_pc    <= '0;
    end else begin
      if (fetch_fire) begin
        o_instr <= i_mem_data;
        o_pc    <= pc;
        o_valid <= 1'b1;
        pc      <= pc + ADDR_W'(1);
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      if (i_redirect) begin
        pc      <= i_redirect_pc;
        o_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_dbg_valid <= 1'b0;
      o_dbg_data  <= '0;
    end else begin
      o_dbg_valid <= o_dbg_gnt;
      if (o_dbg_gnt) o_dbg_data <= i_mem_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl. The instruction memory is
// modelled as mem[n] = n + 0x100; expected values are hand-derived constants.
module tb_instr_fetch_ctrl;
  import instr_fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_start, i_halt, i_redirect, i_ready, i_dbg_req;
  logic [7:0]  i_redirect_pc, i_dbg_addr, o_mem_addr, o_pc;
  logic [31:0] i_mem_data, o_instr, o_dbg_data;
  logic        o_valid, o_dbg_gnt, o_dbg_valid;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_ctrl #(
    .ADDR_W(8), .INSTR_LEN(32), .RESET_PC(8'h00), .DBG_MAX_WAIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_halt(i_halt),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .i_ready(i_ready),
    .i_dbg_req(i_dbg_req), .i_dbg_addr(i_dbg_addr),
    .o_dbg_gnt(o_dbg_gnt), .o_dbg_valid(o_dbg_valid), .o_dbg_data(o_dbg_data)
  );

  assign i_mem_data = 32'h100 + {24'h0, o_mem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (o_valid !== 1'b0)      begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_checks++; if (o_instr !== 32'h0)     begin n_fail++; $display("FAIL reset_instr: got %h want 0", o_instr); end
    n_checks++; if (o_pc !== 8'h00)        begin n_fail++; $display("FAIL reset_pc_out: got %h want 00", o_pc); end
    n_checks++; if (o_dbg_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_dbg_valid: got %b want 0", o_dbg_valid); end
    n_checks++; if (o_dbg_data !== 32'h0)  begin n_fail++; $display("FAIL reset_dbg_data: got %h want 0", o_dbg_data); end
    n_checks++; if (o_mem_addr !== 8'h00)  begin n_fail++; $display("FAIL reset_mem_addr: got %h want 00", o_mem_addr); end
    n_checks++; if (dut.state !== IDLE)    begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
  endtask

  task automatic test_dbg_idle();
    i_dbg_req = 1'b1; i_dbg_addr = 8'h10; #1;
    n_checks++; if (o_dbg_gnt !== 1'b1)    begin n_fail++; $display("FAIL idle_gnt: got %b want 1", o_dbg_gnt); end
    n_checks++; if (o_mem_addr !== 8'h10)  begin n_fail++; $display("FAIL idle_dbg_addr: got %h want 10", o_mem_addr); end
    step(); i_dbg_req = 1'b0; #1;
    n_checks++; if (o_dbg_valid !== 1'b1)      begin n_fail++; $display("FAIL idle_dbg_valid: got %b want 1", o_dbg_valid); end
    n_checks++; if (o_dbg_data !== 32'h110)    begin n_fail++; $display("FAIL idle_dbg_data: got %h want 110", o_dbg_data); end
    n_checks++; if (o_mem_addr !== 8'h00)      begin n_fail++; $display("FAIL idle_pc_kept: got %h want 00", o_mem_addr); end
    step();
    n_checks++; if (o_dbg_valid !== 1'b0)      begin n_fail++; $display("FAIL idle_dbg_pulse: got %b want 0", o_dbg_valid); end
  endtask

  task automatic test_straight_fetch();
    i_ready = 1'b1; i_start = 1'b1;
    step(); i_start = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_latency: got %b want 0", o_valid); end
    step();
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid[%0d]: got %b want 1", k, o_valid); end
      n_checks++; if (o_pc !== 8'(k))   begin n_fail++; $display("FAIL fetch_pc[%0d]: got %h want %h", k, o_pc, 8'(k)); end
      n_checks++; if (o_instr !== 32'h100 + 32'(k)) begin n_fail++; $display("FAIL fetch_instr[%0d]: got %h want %h", k, o_instr, 32'h100 + 32'(k)); end
      step();
    end
  endtask

  task automatic test_backpressure();
    n_checks++; if (o_pc !== 8'h03) begin n_fail++; $display("FAIL bp_start_pc: got %h want 03", o_pc); end
    i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; if (o_valid !== 1'b1)     begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", k, o_valid); end
      n_checks++; if (o_pc !== 8'h03)       begin n_fail++; $display("FAIL bp_pc_hold[%0d]: got %h want 03", k, o_pc); end
      n_checks++; if (o_instr !== 32'h103)  begin n_fail++; $display("FAIL bp_instr_hold[%0d]: got %h want 103", k, o_instr); end
      n_checks++; if (o_mem_addr !== 8'h04) begin n_fail++; $display("FAIL bp_pc_int[%0d]: got %h want 04", k, o_mem_addr); end
    end
    i_ready = 1'b1;
    step();
    n_checks++; if (o_pc !== 8'h04 || o_instr !== 32'h104) begin n_fail++; $display("FAIL bp_release: got %h/%h want 04/104", o_pc, o_instr); end
    step();
    n_checks++; if (o_pc !== 8'h05) begin n_fail++; $display("FAIL bp_next: got %h want 05", o_pc); end
  endtask

  task automatic test_redirect(input logic [7:0] target, input string tag);
    i_redirect = 1'b1; i_redirect_pc = target;
    step(); i_redirect = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL %s_flush: got %b want 0", tag, o_valid); end
    step();
    n_checks++; if (o_valid !== 1'b1 || o_pc !== target) begin n_fail++; $display("FAIL %s_pc: got %b/%h want 1/%h", tag, o_valid, o_pc, target); end
    n_checks++; if (o_instr !== 32'h100 + {24'h0, target}) begin n_fail++; $display("FAIL %s_instr: got %h want %h", tag, o_instr, 32'h100 + {24'h0, target}); end
  endtask

  task automatic test_starvation();
    step();  // o_pc = 0x41, internal pc = 0x42
    i_dbg_req = 1'b1; i_dbg_addr = 8'h20;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (o_dbg_gnt !== 1'b0) begin n_fail++; $display("FAIL starve_nogrant[%0d]: got %b want 0", k, o_dbg_gnt); end
      step();
      n_checks++; if (o_pc !== 8'h42 + 8'(k)) begin n_fail++; $display("FAIL starve_pc[%0d]: got %h want %h", k, o_pc, 8'h42 + 8'(k)); end
    end
    #1;
    n_checks++; if (o_dbg_gnt !== 1'b1 || o_mem_addr !== 8'h20) begin n_fail++; $display("FAIL starve_forced: got %b/%h want 1/20", o_dbg_gnt, o_mem_addr); end
    step(); i_dbg_req = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL starve_bubble: got %b want 0", o_valid); end
    n_checks++; if (o_dbg_valid !== 1'b1 || o_dbg_data !== 32'h120) begin n_fail++; $display("FAIL starve_dbg_data: got %b/%h want 1/120", o_dbg_valid, o_dbg_data); end
    step();
    n_checks++; if (o_valid !== 1'b1 || o_pc !== 8'h46) begin n_fail++; $display("FAIL starve_resume: got %b/%h want 1/46", o_valid, o_pc); end
  endtask

  task automatic test_wrap();
    test_redirect(8'hFE, "wrap_redirect");
    step();
    n_checks++; if (o_pc !== 8'hFF || o_instr !== 32'h1FF) begin n_fail++; $display("FAIL wrap_ff: got %h/%h want FF/1FF", o_pc, o_instr); end
    step();
    n_checks++; if (o_pc !== 8'h00 || o_instr !== 32'h100) begin n_fail++; $display("FAIL wrap_00: got %h/%h want 00/100", o_pc, o_instr); end
  endtask

  task automatic test_halt();
    i_halt = 1'b1; i_start = 1'b1; i_ready = 1'b0;
    step(); i_halt = 1'b0; i_start = 1'b0;
    n_checks++; if (dut.state !== HALTED) begin n_fail++; $display("FAIL halt_state: got %0d want HALTED", dut.state); end
    n_checks++; if (o_valid !== 1'b1 || o_pc !== 8'h00) begin n_fail++; $display("FAIL halt_hold: got %b/%h want 1/00", o_valid, o_pc); end
    i_ready = 1'b1;
    step(); step();
    n_checks++; if (o_valid !== 1'b0 || o_mem_addr !== 8'h01) begin n_fail++; $display("FAIL halt_nofetch: got %b/%h want 0/01", o_valid, o_mem_addr); end
    i_start = 1'b1;
    step(); i_start = 1'b0;
    step();
    n_checks++; if (o_valid !== 1'b1 || o_pc !== 8'h01) begin n_fail++; $display("FAIL halt_restart: got %b/%h want 1/01", o_valid, o_pc); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    step(); rst = 1'b0;
    test_reset();
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_halt = 1'b0; i_redirect = 1'b0;
    i_redirect_pc = 8'h00; i_ready = 1'b0; i_dbg_req = 1'b0; i_dbg_addr = 8'h00;
    step(); step();
    rst = 1'b0;
    test_reset();
    test_dbg_idle();
    test_straight_fetch();
    test_backpressure();
    test_redirect(8'h40, "redirect");
    test_starvation();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequencer and arbiter for the combinational-read instruction memory (instr_mem: i_addr in, i_data_out out, same cycle).
- Owns the program counter and presents fetched words to decode over a valid/ready handshake.
- Supports pipeline redirects and start/halt control.
- Shares the single memory read port with a debug/inspection requester, with bounded starvation.

Parameters:
- ADDR_W, 8, memory word-address width; PC width.
- INSTR_LEN, 32, instruction width.
- RESET_PC, 0, PC value after reset.
- DBG_MAX_WAIT, 4, max consecutive cycles a pending debug request may wait before a forced grant; legal range ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_start  in  1  leave IDLE/HALTED and begin fetching.
- i_halt  in  1  stop fetching.
- i_redirect  in  1  load new PC.
- i_redirect_pc  in  ADDR_W  redirect target.
- o_mem_addr  out  ADDR_W  to instr_mem i_addr.
- i_mem_data  in  INSTR_LEN  from instr_mem i_data_out.
- o_valid  out  1  fetched instruction available.
- o_instr  out  INSTR_LEN  fetched instruction.
- o_pc  out  ADDR_W  address of o_instr.
- i_ready  in  1  decode accepts o_instr.
- i_dbg_req  in  1  debug read request; held until granted.
- i_dbg_addr  in  ADDR_W  debug read address.
- o_dbg_gnt  out  1  combinational; debug owns memory this cycle.
- o_dbg_valid  out  1  registered; o_dbg_data valid, one-cycle pulse.
- o_dbg_data  out  INSTR_LEN  debug read result.

Behaviour:
- Clocking/reset: one clock, clk. Reset is synchronous, active-high (rst), sampled on rising edge.
- Reset values: state=IDLE, pc=RESET_PC, o_valid=0, o_instr=0, o_pc=0, o_dbg_valid=0, o_dbg_data=0, wait_cnt=0. A reset asserted mid-operation discards any held instruction at that edge.
- FSM states: IDLE, RUN, HALTED.
  - IDLE→RUN on i_start.
  - RUN→HALTED on i_halt.
  - HALTED→RUN on i_start.
  - i_halt and i_start together: halt wins.
- stall = o_valid & ~i_ready.
- Debug grant (o_dbg_gnt=1) when i_dbg_req and any of:
  - state≠RUN;
  - stall;
  - wait_cnt==DBG_MAX_WAIT (forced grant).
- wait_cnt:
  - increments each cycle i_dbg_req=1 and o_dbg_gnt=0;
  - clears on grant or when i_dbg_req=0;
  - saturates at DBG_MAX_WAIT.
- o_mem_addr = o_dbg_gnt ? i_dbg_addr : pc.
- fetch_fire = state==RUN & ~i_halt & ~i_redirect & ~stall & ~o_dbg_gnt.
- On fetch_fire (registered, 1-cycle latency from address to o_valid):
  - o_instr<=i_mem_data; o_pc<=pc; o_valid<=1;
  - pc<=pc+1, wrapping modulo 2^ADDR_W (max→0).
- No fire and i_ready: o_valid<=0. o_instr/o_pc hold stable while o_valid & ~i_ready.
- i_redirect, any state:
  - pc<=i_redirect_pc; o_valid<=0 (held/in-flight word flushed, even if i_ready=1 that cycle).
  - Fetch from the new PC starts the next cycle.
  - Redirect with halt: both take effect.
- Debug data: on grant, o_dbg_data<=i_mem_data and o_dbg_valid<=1 next cycle; otherwise o_dbg_valid<=0. The requester drops i_dbg_req the cycle after o_dbg_gnt.
- Halt: the held o_valid word remains until consumed; no new fetch until i_start.
- Throughput: one instruction per cycle with i_ready=1 and no debug traffic.

Decomposition:
- Package instr_fetch_pkg:
  - fetch_state_e enum (IDLE, RUN, HALTED);
  - ADDR_W/INSTR_LEN defaults;
  - RESET_PC default.
- One sub-module, fetch_dbg_arb: grant logic plus wait_cnt starvation counter; inputs i_dbg_req, state_run, stall; output gnt.
- PC, FSM and output register stay in instr_fetch_ctrl.

Test Plan:
- Straight fetch: memory loaded with mem[n]=n+0x100, i_start, i_ready=1 → o_valid from cycle 2 on; o_pc 0,1,2,… with o_instr 0x100,0x101,… each cycle.
- Backpressure: hold i_ready=0 while o_pc=3 → o_instr/o_pc stay 0x103/3, pc stays 4; release → next o_pc=4, nothing skipped or duplicated.
- Redirect: i_redirect with i_redirect_pc=0x40 while o_valid=1, i_ready=1 → o_valid=0 next cycle, then o_pc=0x40, o_instr=0x140.
- Debug in idle/stall: i_dbg_req, i_dbg_addr=0x10 during IDLE → o_dbg_gnt same cycle, o_dbg_valid=1 with o_dbg_data=0x110 next cycle, pc unchanged.
- Starvation: RUN, i_ready=1, i_dbg_req held → grant forced on the 5th cycle (DBG_MAX_WAIT=4); exactly one fetch bubble; o_pc sequence continues without a gap.
- Wrap and reset: ADDR_W=8, redirect to 0xFE → o_pc 0xFE,0xFF,0x00. Assert rst mid-stream → all outputs return to reset values next edge, state IDLE, pc=RESET_PC.
